arcade_input_ctrl: RTL and testbench

- Player-input front end in clk_sys. Decodes ps2_key events and merges them with hps_io joystick words (joystick_0/1).
- Applies opposing-direction cleanup and coin pulse stretching.
- Presents registered, glitch-free player, coin and service signals to the Main core's io_joystick_* inputs.
- Replaces ad-hoc key decoding in emu; all outputs are single-clock-domain registers.

---
 rtl/arcade_input_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_arcade_input_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_ctrl.sv
// Player-input front end: ps2_key decode merged with hps_io joystick words, SOCD cleanup, coin stretch.
// Optional turbo autofire on button 1 when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_ctrl #(
    parameter logic [23:0] COIN_CYCLES     = 24'd1_000_000,
    parameter bit          SOCD_NEUTRAL    = 1'b1,
    parameter logic [23:0] AUTOFIRE_PERIOD = 24'd2_000_000
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic [10:0] ps2_key,
    input  logic [31:0] joystick_0,
    input  logic [31:0] joystick_1,
    output logic [3:0]  p1_dir,
    output logic [2:0]  p1_buttons,
    output logic        p1_start,
    output logic        p1_coin,
    output logic        p1_pause,
    output logic [3:0]  p2_dir,
    output logic [2:0]  p2_buttons,
    output logic        p2_start,
    output logic        p2_coin,
    output logic        p2_pause,
    output logic        service_1,
    output logic        service_2
);

    localparam int K1U  = 0;
    localparam int K1D  = 1;
    localparam int K1L  = 2;
    localparam int K1R  = 3;
    localparam int K1B1 = 4;
    localparam int K1B2 = 5;
    localparam int K1B3 = 6;
    localparam int K1ST = 7;
    localparam int K1CN = 8;
    localparam int K1PA = 9;
    localparam int K2U  = 10;
    localparam int K2D  = 11;
    localparam int K2L  = 12;
    localparam int K2R  = 13;
    localparam int K2B1 = 14;
    localparam int K2B2 = 15;
    localparam int K2B3 = 16;
    localparam int K2ST = 17;
    localparam int K2CN = 18;
    localparam int KSV1 = 19;
    localparam int KSV2 = 20;

    function automatic logic [20:0] key_hit(input logic [7:0] code);
        key_hit = '0;
        case (code)
            8'h75: key_hit[K1U]  = 1'b1;
            8'h72: key_hit[K1D]  = 1'b1;
            8'h6B: key_hit[K1L]  = 1'b1;
            8'h74: key_hit[K1R]  = 1'b1;
            8'h14: key_hit[K1B1] = 1'b1;
            8'h11: key_hit[K1B2] = 1'b1;
            8'h29: key_hit[K1B3] = 1'b1;
            8'h16: key_hit[K1ST] = 1'b1;
            8'h2E: key_hit[K1CN] = 1'b1;
            8'h4D: key_hit[K1PA] = 1'b1;
            8'h2D: key_hit[K2U]  = 1'b1;
            8'h2B: key_hit[K2D]  = 1'b1;
            8'h23: key_hit[K2L]  = 1'b1;
            8'h34: key_hit[K2R]  = 1'b1;
            8'h1C: key_hit[K2B1] = 1'b1;
            8'h1B: key_hit[K2B2] = 1'b1;
            8'h15: key_hit[K2B3] = 1'b1;
            8'h1E: key_hit[K2ST] = 1'b1;
            8'h36: key_hit[K2CN] = 1'b1;
            8'h46: key_hit[KSV1] = 1'b1;
            8'h45: key_hit[KSV2] = 1'b1;
            default: ;
        endcase
    endfunction

    function automatic logic [3:0] socd(input logic [3:0] d);
        socd = d;
        if (SOCD_NEUTRAL) begin
            if (d[3] && d[2]) socd[3:2] = 2'b00;
            if (d[1] && d[0]) socd[1:0] = 2'b00;
        end
    endfunction

    logic        s1_toggle;
    logic        s1_pressed;
    logic [7:0]  s1_code;
    logic        s1_valid;
    logic        armed;
    logic        prev_toggle;
    logic        key_event;
    logic [20:0] keys;
    logic [10:0] j0_r;
    logic [10:0] j1_r;
    logic [23:0] coin1_cnt;
    logic [23:0] coin2_cnt;
    logic        coin1_prev;
    logic        coin2_prev;
    logic        af1;
    logic        af2;

    // armed lags s1_valid so the first compare uses a toggle already sampled after reset
    assign key_event = armed && (s1_toggle != prev_toggle);

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            s1_toggle   <= 1'b0;
            s1_pressed  <= 1'b0;
            s1_code     <= '0;
            s1_valid    <= 1'b0;
            armed       <= 1'b0;
            prev_toggle <= 1'b0;
            keys        <= '0;
            j0_r        <= '0;
            j1_r        <= '0;
        end else begin
            s1_toggle   <= ps2_key[10];
            s1_pressed  <= ps2_key[9];
            s1_code     <= ps2_key[7:0];
            s1_valid    <= 1'b1;
            armed       <= s1_valid;
            prev_toggle <= s1_toggle;
            j0_r        <= joystick_0[10:0];
            j1_r        <= joystick_1[10:0];
            if (key_event)
                keys <= (keys & ~key_hit(s1_code)) | (key_hit(s1_code) & {21{s1_pressed}});
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic [23:0] af_cnt;
    logic        j0_turbo;
    logic        j1_turbo;
    logic        af_phase;
    logic        unused_bits;

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            af_cnt   <= '0;
            j0_turbo <= 1'b0;
            j1_turbo <= 1'b0;
        end else begin
            af_cnt   <= (af_cnt == AUTOFIRE_PERIOD - 24'd1) ? 24'd0 : af_cnt + 24'd1;
            j0_turbo <= joystick_0[11];
            j1_turbo <= joystick_1[11];
        end
    end

    assign af_phase    = af_cnt < (AUTOFIRE_PERIOD >> 1);
    assign af1         = af_phase && j0_turbo;
    assign af2         = af_phase && j1_turbo;
    assign unused_bits = ^{ps2_key[8], joystick_0[31:12], joystick_1[31:12]};
`else
    localparam logic [23:0] UNUSED_AF_PERIOD = AUTOFIRE_PERIOD;
    logic unused_bits;

    assign af1         = 1'b0;
    assign af2         = 1'b0;
    assign unused_bits = ^{ps2_key[8], joystick_0[31:11], joystick_1[31:11]};
`endif

    logic [3:0] raw1_dir;
    logic [3:0] raw2_dir;
    logic [2:0] raw1_btn;
    logic [2:0] raw2_btn;
    logic       raw1_coin;
    logic       raw2_coin;

    assign raw1_dir  = {keys[K1U], keys[K1D], keys[K1L], keys[K1R]} | j0_r[3:0];
    assign raw2_dir  = {keys[K2U], keys[K2D], keys[K2L], keys[K2R]} | j1_r[3:0];
    assign raw1_btn  = {keys[K1B3], keys[K1B2], keys[K1B1] | af1} | j0_r[6:4];
    assign raw2_btn  = {keys[K2B3], keys[K2B2], keys[K2B1] | af2} | j1_r[6:4];
    assign raw1_coin = keys[K1CN] | j0_r[8];
    assign raw2_coin = keys[K2CN] | j1_r[8];

    // Counters decrement even while coin is held; output is the longer of hold time and stretch
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            coin1_cnt  <= '0;
            coin2_cnt  <= '0;
            coin1_prev <= 1'b0;
            coin2_prev <= 1'b0;
            p1_dir     <= '0;
            p1_buttons <= '0;
            p1_start   <= 1'b0;
            p1_coin    <= 1'b0;
            p1_pause   <= 1'b0;
            p2_dir     <= '0;
            p2_buttons <= '0;
            p2_start   <= 1'b0;
            p2_coin    <= 1'b0;
            p2_pause   <= 1'b0;
            service_1  <= 1'b0;
            service_2  <= 1'b0;
        end else begin
            coin1_prev <= raw1_coin;
            coin2_prev <= raw2_coin;
            if (raw1_coin && !coin1_prev)
                coin1_cnt <= COIN_CYCLES - 24'd1;
            else if (coin1_cnt != 24'd0)
                coin1_cnt <= coin1_cnt - 24'd1;
            if (raw2_coin && !coin2_prev)
                coin2_cnt <= COIN_CYCLES - 24'd1;
            else if (coin2_cnt != 24'd0)
                coin2_cnt <= coin2_cnt - 24'd1;

            p1_dir     <= socd(raw1_dir);
            p1_buttons <= raw1_btn;
            p1_start   <= keys[K1ST] | j0_r[7];
            p1_coin    <= raw1_coin | (coin1_cnt != 24'd0);
            p1_pause   <= keys[K1PA] | j0_r[9];
            p2_dir     <= socd(raw2_dir);
            p2_buttons <= raw2_btn;
            p2_start   <= keys[K2ST] | j1_r[7];
            p2_coin    <= raw2_coin | (coin2_cnt != 24'd0);
            p2_pause   <= j1_r[9];
            service_1  <= keys[KSV1] | j0_r[10];
            service_2  <= keys[KSV2] | j1_r[10];
        end
    end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Scoreboard bench for arcade_input_ctrl: random ps2/joystick stimulus against a behavioural model.
module tb_arcade_input_ctrl;

    localparam logic [23:0] CC = 24'd10;
    localparam logic [23:0] AP = 24'd8;

    logic        clk_sys = 1'b0;
    logic        RESET   = 1'b1;
    logic [10:0] ps2_key;
    logic [31:0] joystick_0;
    logic [31:0] joystick_1;

    logic [3:0] p1_dir, p2_dir, n_p1_dir, n_p2_dir;
    logic [2:0] p1_buttons, p2_buttons, n_p1_buttons, n_p2_buttons;
    logic       p1_start, p1_coin, p1_pause, p2_start, p2_coin, p2_pause, service_1, service_2;
    logic       n_p1_start, n_p1_coin, n_p1_pause, n_p2_start, n_p2_coin, n_p2_pause;
    logic       n_service_1, n_service_2;

    arcade_input_ctrl #(.COIN_CYCLES(CC), .SOCD_NEUTRAL(1'b1), .AUTOFIRE_PERIOD(AP)) dut (
        .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1),
        .p1_dir(p1_dir), .p1_buttons(p1_buttons), .p1_start(p1_start),
        .p1_coin(p1_coin), .p1_pause(p1_pause),
        .p2_dir(p2_dir), .p2_buttons(p2_buttons), .p2_start(p2_start),
        .p2_coin(p2_coin), .p2_pause(p2_pause),
        .service_1(service_1), .service_2(service_2)
    );

    arcade_input_ctrl #(.COIN_CYCLES(CC), .SOCD_NEUTRAL(1'b0), .AUTOFIRE_PERIOD(AP)) dut_raw (
        .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1),
        .p1_dir(n_p1_dir), .p1_buttons(n_p1_buttons), .p1_start(n_p1_start),
        .p1_coin(n_p1_coin), .p1_pause(n_p1_pause),
        .p2_dir(n_p2_dir), .p2_buttons(n_p2_buttons), .p2_start(n_p2_start),
        .p2_coin(n_p2_coin), .p2_pause(n_p2_pause),
        .service_1(n_service_1), .service_2(n_service_2)
    );

    always #5 clk_sys = ~clk_sys;

    logic [29:0] act_vec;
    assign act_vec = {p1_dir, p1_buttons, p1_start, p1_coin, p1_pause,
                      p2_dir, p2_buttons, p2_start, p2_coin, p2_pause,
                      service_1, service_2, n_p1_dir, n_p2_dir};

    int vectors     = 0;
    int miscompares = 0;
    logic [29:0] exp_q[$];

    // Behavioural model state
    int          n;
    logic [10:0] ps2_d1, ps2_d2;
    logic [31:0] j0_d, j1_d;
    bit          key_st [256];
    int          last_rise [2];
    bit          prev_coin [2];

    function automatic logic [1:0] axis(input bit neutral, input logic a, input logic b);
        return (neutral && a && b) ? 2'b00 : {a, b};
    endfunction

    task automatic model_reset();
        n = 0;
        ps2_d1 = '0;
        ps2_d2 = '0;
        j0_d = '0;
        j1_d = '0;
        for (int i = 0; i < 256; i++) key_st[i] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            last_rise[p] = -1000;
            prev_coin[p] = 1'b0;
        end
    endtask

    always @(posedge clk_sys) begin : model
        logic [3:0] d1, d2;
        logic [2:0] b1v, b2v;
        logic       c1, c2, af1, af2, o1, o2;
        if (RESET) begin
            model_reset();
        end else begin
            d1 = {key_st[8'h75] | j0_d[3], key_st[8'h72] | j0_d[2],
                  key_st[8'h6B] | j0_d[1], key_st[8'h74] | j0_d[0]};
            d2 = {key_st[8'h2D] | j1_d[3], key_st[8'h2B] | j1_d[2],
                  key_st[8'h23] | j1_d[1], key_st[8'h34] | j1_d[0]};
`ifdef ARCADE_INPUT_AUTOFIRE_EN
            af1 = j0_d[11] && ((n % int'(AP)) < int'(AP) / 2);
            af2 = j1_d[11] && ((n % int'(AP)) < int'(AP) / 2);
`else
            af1 = 1'b0;
            af2 = 1'b0;
`endif
            b1v = {key_st[8'h29] | j0_d[6], key_st[8'h11] | j0_d[5], key_st[8'h14] | j0_d[4] | af1};
            b2v = {key_st[8'h15] | j1_d[6], key_st[8'h1B] | j1_d[5], key_st[8'h1C] | j1_d[4] | af2};
            c1 = key_st[8'h2E] | j0_d[8];
            c2 = key_st[8'h36] | j1_d[8];
            if (c1 && !prev_coin[0]) last_rise[0] = n;
            if (c2 && !prev_coin[1]) last_rise[1] = n;
            prev_coin[0] = c1;
            prev_coin[1] = c2;
            o1 = c1 || (n - last_rise[0] < int'(CC));
            o2 = c2 || (n - last_rise[1] < int'(CC));
            exp_q.push_back({axis(1'b1, d1[3], d1[2]), axis(1'b1, d1[1], d1[0]), b1v,
                             key_st[8'h16] | j0_d[7], o1, key_st[8'h4D] | j0_d[9],
                             axis(1'b1, d2[3], d2[2]), axis(1'b1, d2[1], d2[0]), b2v,
                             key_st[8'h1E] | j1_d[7], o2, j1_d[9],
                             key_st[8'h46] | j0_d[10], key_st[8'h45] | j1_d[10],
                             d1, d2});
            // a toggle edge seen two samples back counts only once both samples postdate reset
            if (n >= 2 && ps2_d1[10] != ps2_d2[10]) key_st[ps2_d1[7:0]] = ps2_d1[9];
            ps2_d2 = ps2_d1;
            ps2_d1 = ps2_key;
            j0_d = joystick_0;
            j1_d = joystick_1;
            n++;
        end
    end

    always @(posedge clk_sys) begin : monitor
        logic [29:0] e;
        #1;
        if (!RESET) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_empty t=%0t got %h required an expectation", $time, act_vec);
            end else begin
                e = exp_q.pop_front();
                if (act_vec !== e) begin
                    miscompares++;
                    $display("FAIL out_vec t=%0t got %h required %h", $time, act_vec, e);
                end
            end
        end
    end

    logic [7:0] codes [23] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h16,
                               8'h2E, 8'h4D, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B,
                               8'h15, 8'h1E, 8'h36, 8'h46, 8'h45, 8'h5A, 8'h00};

    function automatic logic [31:0] flip_bits(input logic [31:0] j);
        logic [31:0] r = j;
        for (int b = 0; b < 32; b++)
            if ($urandom_range(0, 15) == 0) r[b] = ~r[b];
        return r;
    endfunction

    task automatic mid_reset();
        @(posedge clk_sys);
        #3;
        RESET = 1'b1;
        #1;
        vectors++;
        if (act_vec !== 30'd0) begin
            miscompares++;
            $display("FAIL reset_clear t=%0t got %h required 0", $time, act_vec);
        end
        @(negedge clk_sys);
        @(negedge clk_sys);
        RESET = 1'b0;
    endtask

    initial begin
        model_reset();
        ps2_key    = {1'b1, 1'b1, 1'b0, 8'h75};
        joystick_0 = '0;
        joystick_1 = '0;
        repeat (3) @(negedge clk_sys);
        RESET = 1'b0;
        repeat (100) @(negedge clk_sys);
        ps2_key = {1'b0, 1'b1, 1'b0, 8'h75};
        repeat (6) @(negedge clk_sys);
        joystick_0 = 32'h0000_000C;
        repeat (4) @(negedge clk_sys);
        joystick_0 = 32'h0000_0008;
        repeat (4) @(negedge clk_sys);
        joystick_0 = 32'h0000_0100;
        @(negedge clk_sys);
        joystick_0 = '0;
        repeat (14) @(negedge clk_sys);

        for (int c = 0; c < 4000; c++) begin
            case ($urandom_range(0, 7))
                0: ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              codes[$urandom_range(0, 22)]};
                1: ps2_key = {ps2_key[10], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              codes[$urandom_range(0, 22)]};
                default: ;
            endcase
            joystick_0 = flip_bits(joystick_0);
            joystick_1 = flip_bits(joystick_1);
            if (c % 700 == 350) begin
                mid_reset();
                // hold ps2 toggle steady so a latched key stays released until a fresh event
                repeat (5) @(negedge clk_sys);
            end
            @(negedge clk_sys);
        end

        repeat (3) @(negedge clk_sys);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
